conv_seq_mac: RTL and testbench

//  Sequential, parametrised successor to the combinational 8x8 linear convolver.

---
 rtl/conv_seq_mac_if.sv | 32 +++
 rtl/conv_seq_mac.sv | 193 +++++++++++++++++++
 tb/tb_conv_seq_mac.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_mac_if.sv
// conv_seq_mac_if
//   Stream bundle for conv_seq_mac: one valid/ready sample input stream and
//   one valid/ready result output stream.
//   Signals:
//     in_valid / in_ready / in_data   sample stream (x values, then h values)
//     y_valid  / y_ready  / y_data    convolution result stream
//     y_last                          marks the final result of a job
//   Modports:
//     master  source/sink side (drives samples, accepts results)
//     slave   convolver side
interface conv_seq_mac_if #(
    parameter int DW = 4,
    parameter int YW = 11
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          y_valid;
    logic          y_ready;
    logic [YW-1:0] y_data;
    logic          y_last;

    modport master (
        output in_valid, in_data, y_ready,
        input  in_ready, y_valid, y_data, y_last
    );

    modport slave (
        input  in_valid, in_data, y_ready,
        output in_ready, y_valid, y_data, y_last
    );
endinterface

// File: rtl/conv_seq_mac.sv
// conv_seq_mac
//   Sequential linear convolver with a single shared multiply-accumulate.
//   Loads x[0..N-1] then h[0..M-1] from the input stream, then produces
//   y[k] = sum_j x[j]*h[k-j] for k = 0..N+M-2, one term per clock (N clocks
//   per output), streaming each y over valid/ready with backpressure.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     io     conv_seq_mac_if.slave (in_valid/in_ready/in_data,
//            y_valid/y_ready/y_data/y_last)
//     busy   high while computing or presenting a result
//   Build option:
//     CONV_SAT_EN  when defined, results that do not fit in YW bits saturate
//                  to all ones; otherwise they are truncated modulo 2**YW.
module conv_seq_mac #(
    parameter int DW = 4,
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int YW = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_seq_mac_if.slave  io,
    output logic           busy
);
    localparam int ACC_W = 2*DW + $clog2(N+1);
    localparam int CW    = $clog2(((N > M) ? N : M) + 1);
    localparam int JW    = $clog2(N+1);
    localparam int KW    = $clog2(N+M);
    localparam int EW    = (YW > ACC_W) ? YW : ACC_W;

    typedef enum logic [1:0] {LOAD_X, LOAD_H, COMPUTE, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [DW-1:0]    x_q [N];
    logic [DW-1:0]    x_d [N];
    logic [DW-1:0]    h_q [M];
    logic [DW-1:0]    h_d [M];
    logic [YW-1:0]    y_data_q, y_data_d;
    logic             y_valid_q, y_valid_d;
    logic             y_last_q, y_last_d;

    logic             in_fire, out_fire;
    logic             last_load_x, last_load_h, last_term, last_k;
    logic [DW-1:0]    x_sel, h_sel;
    logic             in_range;
    logic [2*DW-1:0]  term;
    logic [ACC_W-1:0] acc_sum;

    // Result formatting in front of the y_data register.
    function automatic logic [YW-1:0] fmt(input logic [ACC_W-1:0] v);
        logic [EW-1:0] ve;
        ve = EW'(v);
`ifdef CONV_SAT_EN
        if (ve > EW'({YW{1'b1}}))
            return {YW{1'b1}};
`endif
        return ve[YW-1:0];
    endfunction

    assign in_fire     = io.in_valid && io.in_ready;
    assign out_fire    = y_valid_q && io.y_ready;
    assign last_load_x = (cnt_q == CW'(N-1));
    assign last_load_h = (cnt_q == CW'(M-1));
    assign last_term   = (j_q == JW'(N-1));
    assign last_k      = (k_q == KW'(N+M-2));

    assign io.y_data  = y_data_q;
    assign io.y_valid = y_valid_q;
    assign io.y_last  = y_last_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LOAD_X;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_X:  if (in_fire && last_load_x) state_d = LOAD_H;
            LOAD_H:  if (in_fire && last_load_h) state_d = COMPUTE;
            COMPUTE: if (last_term)              state_d = OUTPUT;
            OUTPUT:  if (out_fire)               state_d = y_last_q ? LOAD_X : COMPUTE;
            default:                             state_d = LOAD_X;
        endcase
    end

    // FSM outputs
    always_comb begin
        io.in_ready = (state_q == LOAD_X) || (state_q == LOAD_H);
        busy        = (state_q == COMPUTE) || (state_q == OUTPUT);
    end

    // MAC term: x[j]*h[k-j], zero where k-j falls outside 0..M-1
    always_comb begin
        x_sel    = '0;
        h_sel    = '0;
        in_range = 1'b0;
        for (int i = 0; i < N; i++)
            if (JW'(i) == j_q) x_sel = x_q[i];
        for (int i = 0; i < M; i++)
            if (int'(k_q) - int'(j_q) == i) begin
                h_sel    = h_q[i];
                in_range = 1'b1;
            end
        term    = in_range ? ({{DW{1'b0}}, x_sel} * {{DW{1'b0}}, h_sel}) : '0;
        acc_sum = acc_q + ACC_W'(term);
    end

    // Counters, buffers, accumulator and result register next values
    always_comb begin
        cnt_d     = cnt_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x_d       = x_q;
        h_d       = h_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;
        case (state_q)
            LOAD_X: if (in_fire) begin
                for (int i = 0; i < N; i++)
                    if (CW'(i) == cnt_q) x_d[i] = io.in_data;
                cnt_d = last_load_x ? '0 : cnt_q + CW'(1);
            end
            LOAD_H: if (in_fire) begin
                for (int i = 0; i < M; i++)
                    if (CW'(i) == cnt_q) h_d[i] = io.in_data;
                cnt_d = last_load_h ? '0 : cnt_q + CW'(1);
                if (last_load_h) begin
                    k_d   = '0;
                    j_d   = '0;
                    acc_d = '0;
                end
            end
            COMPUTE: begin
                acc_d = acc_sum;
                if (last_term) begin
                    y_data_d  = fmt(acc_sum);
                    y_valid_d = 1'b1;
                    y_last_d  = last_k;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            OUTPUT: if (out_fire) begin
                y_valid_d = 1'b0;
                if (y_last_q) begin
                    y_last_d = 1'b0;
                end else begin
                    k_d   = k_q + KW'(1);
                    j_d   = '0;
                    acc_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
            for (int i = 0; i < N; i++) x_q[i] <= '0;
            for (int i = 0; i < M; i++) h_q[i] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
            x_q       <= x_d;
            h_q       <= h_d;
        end
    end
endmodule

// File: tb/tb_conv_seq_mac.sv
module tb_conv_seq_mac;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, y_ready;
    logic [3:0] in_data;
    logic       c_valid, c_ready;
    logic [3:0] c_data;
    logic       busy_a, busy_b, busy_c;

    conv_seq_mac_if #(.DW(4), .YW(11)) ifa ();
    conv_seq_mac_if #(.DW(4), .YW(4))  ifb ();
    conv_seq_mac_if #(.DW(4), .YW(11)) ifc ();

    assign ifa.in_valid = in_valid;
    assign ifa.in_data  = in_data;
    assign ifa.y_ready  = y_ready;
    assign ifb.in_valid = in_valid;
    assign ifb.in_data  = in_data;
    assign ifb.y_ready  = y_ready;
    assign ifc.in_valid = c_valid;
    assign ifc.in_data  = c_data;
    assign ifc.y_ready  = c_ready;

    conv_seq_mac #(.DW(4), .N(8), .M(8), .YW(11)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa), .busy(busy_a));
    conv_seq_mac #(.DW(4), .N(8), .M(8), .YW(4))  dut_b (.clk(clk), .rst_n(rst_n), .io(ifb), .busy(busy_b));
    conv_seq_mac #(.DW(4), .N(3), .M(1), .YW(11)) dut_c (.clk(clk), .rst_n(rst_n), .io(ifc), .busy(busy_c));

    typedef struct {
        logic [7:0][3:0]   x;
        logic [7:0][3:0]   h;
        logic [14:0][10:0] y;
        bit                gaps;
        bit                junk;
    } job_t;

    int checks = 0;
    int errors = 0;

    // Edge monitor: records every output handshake and input acceptance
    int qa_y[$], qa_last[$], qa_cyc[$], qb_y[$], qc_y[$], qc_last[$];
    int cyc = 0, acc_n = 0, hcyc = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ifa.y_valid && ifa.y_ready) begin
                qa_y.push_back(int'(ifa.y_data));
                qa_last.push_back(int'(ifa.y_last));
                qa_cyc.push_back(cyc);
            end
            if (ifb.y_valid && ifb.y_ready) qb_y.push_back(int'(ifb.y_data));
            if (ifc.y_valid && ifc.y_ready) begin
                qc_y.push_back(int'(ifc.y_data));
                qc_last.push_back(int'(ifc.y_last));
            end
            if (ifa.in_valid && ifa.in_ready) begin
                acc_n <= acc_n + 1;
                hcyc  <= cyc;
            end
        end
        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic put_a(input logic [3:0] v);
        int t;
        t = 0;
        while (!ifa.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: in_ready=%0d after %0d cycles, required 1", ifa.in_ready, t);
        end
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_a(input job_t jb);
        for (int i = 0; i < 8; i++) begin
            put_a(jb.x[i]);
            if (jb.gaps) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            put_a(jb.h[i]);
            if (jb.gaps && i < 7) @(negedge clk);
        end
    endtask

    task automatic wait_a(input int n);
        int t;
        t = 0;
        while (qa_y.size() < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (qa_y.size() < n) begin
            checks++;
            errors++;
            $display("FAIL out_wait: got %0d outputs, required %0d", qa_y.size(), n);
        end
    endtask

    task automatic clear_q();
        qa_y.delete(); qa_last.delete(); qa_cyc.delete();
        qb_y.delete(); qc_y.delete(); qc_last.delete();
    endtask

    task automatic chk_seq(input string nm, input job_t jb);
        chk({nm, "_count"}, qa_y.size(), 15);
        for (int k = 0; k < 15; k++) begin
            if (k < qa_y.size()) begin
                chk($sformatf("%s_y%0d", nm, k), qa_y[k], int'(jb.y[k]));
                chk($sformatf("%s_last%0d", nm, k), qa_last[k], (k == 14) ? 1 : 0);
            end
        end
    endtask

    int   y_t1[15] = '{1, 3, 6, 10, 15, 21, 28, 36, 35, 33, 30, 26, 21, 15, 8};
    int   y_t2[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
`ifdef CONV_SAT_EN
    int   yb_exp[4] = '{15, 15, 15, 15};
`else
    int   yb_exp[4] = '{15, 5, 12, 4};
`endif
    int   cv[4] = '{2, 3, 4, 5};
    int   cy[3] = '{10, 15, 20};
    job_t jobs[3];

    initial begin
        int h_at, acc0, t;

        for (int i = 0; i < 8; i++) begin
            jobs[0].x[i] = 4'(i + 1); jobs[0].h[i] = 4'd1;
            jobs[1].x[i] = 4'd1;      jobs[1].h[i] = 4'd1;
            jobs[2].x[i] = 4'(i + 1); jobs[2].h[i] = 4'd1;
        end
        for (int k = 0; k < 15; k++) begin
            jobs[0].y[k] = 11'(y_t1[k]);
            jobs[1].y[k] = 11'(y_t2[k]);
            jobs[2].y[k] = 11'(y_t1[k]);
        end
        jobs[0].gaps = 1'b0; jobs[0].junk = 1'b0;
        jobs[1].gaps = 1'b0; jobs[1].junk = 1'b0;
        jobs[2].gaps = 1'b1; jobs[2].junk = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; y_ready = 1'b1;
        c_valid = 1'b0; c_data = '0; c_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_y_valid", ifa.y_valid, 0);
        chk("rst_y_last", ifa.y_last, 0);
        chk("rst_y_data", ifa.y_data, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_c_in_ready", ifc.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Jobs 0/1 back to back, job 2 with input gaps and junk during compute
        for (int jb = 0; jb < 3; jb++) begin
            clear_q();
            acc0 = acc_n;
            load_a(jobs[jb]);
            h_at = hcyc;
            if (jobs[jb].junk) begin
                for (int i = 0; i < 3; i++) begin
                    chk("compute_in_ready", ifa.in_ready, 0);
                    in_valid = 1'b1;
                    in_data  = 4'd15;
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            wait_a(15);
            chk("done_in_ready", ifa.in_ready, 1);
            chk("done_busy", busy_a, 0);
            chk("done_y_valid", ifa.y_valid, 0);
            chk("accepted", acc_n - acc0, 16);
            chk_seq($sformatf("job%0d", jb), jobs[jb]);
            if (qa_cyc.size() == 15) begin
                // y[0] registered N=8 edges after h[7]; taken on the following edge
                chk("y0_latency", qa_cyc[0] - h_at, 9);
                for (int k = 0; k < 14; k++)
                    chk("spacing", qa_cyc[k+1] - qa_cyc[k], 9);
            end
            if (jb == 0 && qb_y.size() == 15) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("yw4_y%0d", k + 4), qb_y[k+4], yb_exp[k]);
                chk("yw4_y14", qb_y[14], 8);
            end
        end

        // Backpressure on y[3]
        clear_q();
        load_a(jobs[0]);
        t = 0;
        while (!(ifa.y_valid && qa_y.size() == 3) && t < 200) begin
            @(negedge clk);
            t++;
        end
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y_valid", ifa.y_valid, 1);
            chk("bp_y_data", ifa.y_data, 10);
        end
        chk("bp_no_take", qa_y.size(), 3);
        y_ready = 1'b1;
        wait_a(15);
        chk_seq("bp", jobs[0]);
        if (qa_cyc.size() == 15) chk("bp_y4_gap", qa_cyc[4] - qa_cyc[3], 9);

        // Reset while computing k=5
        clear_q();
        load_a(jobs[0]);
        wait_a(5);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y_valid", ifa.y_valid, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_in_ready", ifa.in_ready, 1);
        chk("mid_rst_y_data", ifa.y_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        load_a(jobs[1]);
        wait_a(15);
        chk_seq("after_rst", jobs[1]);

        // N=3, M=1 instance
        for (int i = 0; i < 4; i++) begin
            chk("c_in_ready", ifc.in_ready, 1);
            c_valid = 1'b1;
            c_data  = 4'(cv[i]);
            @(negedge clk);
            c_valid = 1'b0;
        end
        t = 0;
        while (qc_y.size() < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("c_count", qc_y.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < qc_y.size()) begin
                chk($sformatf("c_y%0d", k), qc_y[k], cy[k]);
                chk($sformatf("c_last%0d", k), qc_last[k], (k == 2) ? 1 : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
